layer_arbiter: RTL and testbench
================================

Name: layer_arbiter

Overview:
- Shares the single RGB input of vga_sync between N_REQ pixel generators (bars, sprites, gray ramp), so no net has multiple drivers.
- Each cycle, picks one winner per pixel by priority, either fixed or rotated once per frame, and registers its colour.
- Latches per-frame collision flags.
- Applies enable-mask updates only at frame boundaries, so a frame is never torn.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CW, 10, colour channel width
- BG_COLOR, 30'h0000_0000, {R,G,B} output when no requester wins

Ports:
- iCLK  in  1  pixel clock (VGA_CTRL_CLK)
- iRST  in  1  synchronous reset, active-high
- iValid  in  1  pixel slot valid (active video)
- iFrameStart  in  1  one-cycle pulse at px=0, py=0
- iReq  in  N_REQ  per-requester "pixel hit" flag
- iRGB  in  N_REQ*3*CW  packed {R,G,B} per requester; requester k at bits [k*3*CW +: 3*CW]
- iRrEn  in  1  1 = rotate priority each frame, 0 = fixed (index 0 highest)
- iCfgWe  in  1  write strobe for enable mask
- iCfgMask  in  N_REQ  new enable mask
- oRed, oGreen, oBlue  out  CW each  arbitrated colour
- oValid  out  1  iValid delayed to align with colour
- oGrant  out  N_REQ  one-hot winner, 0 if none
- oCollision  out  N_REQ  requesters that overlapped during the previous frame
- oCfgPending  out  1  shadow mask not yet applied

Behaviour:
Reset (iRST=1 at a rising edge):
- oRed/oGreen/oBlue=0, oValid=0, oGrant=0, oCollision=0, oCfgPending=0.
- Active mask = shadow mask = all ones; rr pointer = 0; working collision register = 0.
- Reset mid-frame discards pipeline contents.

Pipeline, fixed latency 2 cycles from iReq/iRGB/iValid to outputs:
- S1 registers eff = iReq & active_mask, plus iRGB and iValid.
- S2 arbitrates and registers the winner's colour, oGrant and oValid.
- Requesters must compute the colour for pixel px+2 so the output aligns with vga_sync.

Arbitration:
- The priority order starts at index ptr and proceeds ptr, ptr+1, ..., wrapping modulo N_REQ.
- The winner is the first set bit of eff in that order.
- No bit set, or S1 valid = 0: colour = BG_COLOR, oGrant = 0.
- When iValid = 0 the colour output is forced to BG_COLOR.

Round-robin pointer:
- On iFrameStart with iRrEn=1: ptr <= (ptr == N_REQ-1) ? 0 : ptr+1.
- With iRrEn=0: ptr forced to 0 at the next iFrameStart and held there.

Collision:
- A collision occurs on any S1 cycle with valid = 1 and popcount(eff) >= 2.
- On a collision, working |= eff.
- On iFrameStart: oCollision <= working, and working <= collision bits of that same cycle (or 0). No hit is ever lost.

Config:
- iCfgWe writes the shadow mask and sets oCfgPending.
- On iFrameStart: active <= (iCfgWe ? iCfgMask : shadow) and oCfgPending clears. A write on the frame-start cycle takes effect immediately.
- Multiple writes in one frame: the last one wins.
- The mask gates iReq at S1 entry, so a mask change affects pixels 2 cycles later.

Arithmetic:
- Priority search uses a double-width rotate of eff, which avoids any variable-length loop.
- ptr has $clog2(N_REQ) bits.

Decomposition:
- Shared package vga_pkg:
  - CW, BG_COLOR
  - rgb_t packed struct {r,g,b}
  - function rr_pick(eff, ptr) returning one-hot
- One sub-module, rr_priority_pick: combinational rotate + find-first + un-rotate, reused later by the sprite-memory arbiter.
- Pipeline, pointer, collision and config registers stay in layer_arbiter.

Test Plan:
1. Reset, iValid=1, iReq=4'b0000 → after 2 cycles colour=BG_COLOR, oGrant=0, oValid=1; oCollision=0.
2. Fixed mode, iReq=4'b0110, requester1 RGB={10'h3FF,0,0}, requester2={0,10'h3FF,0} → oGrant=4'b0010, oRed=3FF, oGreen=0, exactly 2 cycles later.
3. iRrEn=1, hold iReq=4'b1111 across 5 iFrameStart pulses → first-pixel oGrant sequence 0001, 0010, 0100, 1000, 0001.
4. Frame with a single overlap of requesters 0 and 3 at mid-frame, then iFrameStart → oCollision=4'b1001 for the whole next frame; cleared after a following clean frame. An overlap on the frame-start cycle appears one frame later.
5. Mid-frame iCfgWe, iCfgMask=4'b1110, iReq=4'b0011 → oGrant stays 0001 until iFrameStart, then 0010; oCfgPending high between the write and the frame start. A write coincident with iFrameStart applies on the next pixel +2.
6. Assert iRST mid-frame with pending config and collisions → next cycle all outputs 0, active mask = 1111, ptr = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour types and the rotating priority pick
package vga_pkg;

  localparam int CW = 10;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } rgb_t;

  localparam rgb_t BG_COLOR = rgb_t'(30'h0000_0000);

  // One-hot winner among the low n bits of eff, searching from ptr upward with wrap.
  function automatic logic [7:0] rr_pick(input logic [7:0] eff, input logic [2:0] ptr, input int n);
    logic [15:0] mask;
    logic [15:0] dbl;
    logic [15:0] rot;
    logic [15:0] first;
    logic [15:0] unrot;
    mask  = (16'd1 << n) - 16'd1;
    dbl   = ({8'd0, eff} & mask) | (({8'd0, eff} & mask) << n);
    rot   = (dbl >> ptr) & mask;
    first = rot & (~rot + 16'd1);
    unrot = (first | (first << n)) << ptr;
    return 8'((unrot >> n) & mask);
  endfunction

endpackage

// File: rtl/layer_arbiter_if.sv
// rtl/layer_arbiter_if.sv - requester-side and VGA-side bundle of the layer arbiter
interface layer_arbiter_if #(parameter int N_REQ = 4);
  import vga_pkg::*;

  logic                    iValid;
  logic                    iFrameStart;
  logic [N_REQ-1:0]        iReq;
  logic [N_REQ*3*CW-1:0]   iRGB;
  logic                    iRrEn;
  logic                    iCfgWe;
  logic [N_REQ-1:0]        iCfgMask;
  logic [CW-1:0]           oRed;
  logic [CW-1:0]           oGreen;
  logic [CW-1:0]           oBlue;
  logic                    oValid;
  logic [N_REQ-1:0]        oGrant;
  logic [N_REQ-1:0]        oCollision;
  logic                    oCfgPending;

  modport master (
    output iValid, iFrameStart, iReq, iRGB, iRrEn, iCfgWe, iCfgMask,
    input  oRed, oGreen, oBlue, oValid, oGrant, oCollision, oCfgPending
  );

  modport slave (
    input  iValid, iFrameStart, iReq, iRGB, iRrEn, iCfgWe, iCfgMask,
    output oRed, oGreen, oBlue, oValid, oGrant, oCollision, oCfgPending
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotate, find-first-set, un-rotate; combinational
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eff,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  // Doubling the vector turns the wrap-around search into a plain shift.
  always_comb begin
    rot   = N'({eff, eff} >> ptr);
    first = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    grant = N'(({first, first} << ptr) >> N);
  end

endmodule

// File: rtl/layer_arbiter.sv
// rtl/layer_arbiter.sv - per-pixel colour arbiter between layer generators feeding vga_sync
// Two-stage pipeline; priority pointer, enable mask and collision flags change only at frame start.
module layer_arbiter #(
  parameter int            N_REQ    = 4,
  parameter vga_pkg::rgb_t BG_COLOR = vga_pkg::BG_COLOR
) (
  input logic             iCLK,
  input logic             iRST,
  layer_arbiter_if.slave  bus
);
  import vga_pkg::*;

  localparam int PW   = $clog2(N_REQ);
  localparam int RGBW = 3 * CW;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    LAST = PW'(N_REQ - 1);

  logic [N_REQ-1:0]      active_mask;
  logic [N_REQ-1:0]      shadow_mask;
  logic [N_REQ-1:0]      working;
  logic [PW-1:0]         ptr;
  logic [N_REQ-1:0]      s1_eff;
  logic [N_REQ*RGBW-1:0] s1_rgb;
  logic                  s1_valid;
  logic [N_REQ-1:0]      pick_grant;
  logic [N_REQ-1:0]      s2_grant;
  logic [N_REQ-1:0]      s1_hit;
  rgb_t                  s2_rgb;

  rr_priority_pick #(.N(N_REQ)) u_pick (
    .eff   (s1_eff),
    .ptr   (ptr),
    .grant (pick_grant)
  );

  always_comb begin
    s2_grant = s1_valid ? pick_grant : '0;
    s2_rgb   = BG_COLOR;
    for (int k = 0; k < N_REQ; k++) begin
      if (s2_grant[k]) s2_rgb = s1_rgb[k*RGBW +: RGBW];
    end
    // Two or more surviving hits on one active pixel is an overlap.
    s1_hit = (s1_valid && |(s1_eff & (s1_eff - ONE))) ? s1_eff : '0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_eff          <= '0;
      s1_rgb          <= '0;
      s1_valid        <= 1'b0;
      bus.oRed        <= '0;
      bus.oGreen      <= '0;
      bus.oBlue       <= '0;
      bus.oValid      <= 1'b0;
      bus.oGrant      <= '0;
      bus.oCollision  <= '0;
      bus.oCfgPending <= 1'b0;
      active_mask     <= '1;
      shadow_mask     <= '1;
      working         <= '0;
      ptr             <= '0;
    end else begin
      s1_eff     <= bus.iReq & active_mask;
      s1_rgb     <= bus.iRGB;
      s1_valid   <= bus.iValid;
      bus.oRed   <= s2_rgb.r;
      bus.oGreen <= s2_rgb.g;
      bus.oBlue  <= s2_rgb.b;
      bus.oGrant <= s2_grant;
      bus.oValid <= s1_valid;

      if (bus.iCfgWe) shadow_mask <= bus.iCfgMask;

      if (bus.iFrameStart) begin
        ptr             <= !bus.iRrEn ? '0 : (ptr == LAST) ? '0 : ptr + PW'(1);
        active_mask     <= bus.iCfgWe ? bus.iCfgMask : shadow_mask;
        bus.oCfgPending <= 1'b0;
        bus.oCollision  <= working;
        // An overlap seen on the boundary cycle seeds the new frame rather than being dropped.
        working         <= s1_hit;
      end else begin
        if (bus.iCfgWe) bus.oCfgPending <= 1'b1;
        working <= working | s1_hit;
      end
    end
  end

endmodule

// File: tb/tb_layer_arbiter.sv
// tb/tb_layer_arbiter.sv - scenario tasks plus a latency-2 scoreboard for layer_arbiter
module tb_layer_arbiter;

  typedef struct {
    logic [3:0]  grant;
    logic [29:0] rgb;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rr_en = 1'b0;
  logic [29:0] rgb_tab [4];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  int         m_ptr = 0;
  logic [3:0] m_active = 4'hF;
  logic [3:0] m_shadow = 4'hF;

  layer_arbiter_if #(.N_REQ(4)) bus ();

  layer_arbiter #(.N_REQ(4)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.iRGB = {rgb_tab[3], rgb_tab[2], rgb_tab[1], rgb_tab[0]};

  function automatic logic [3:0] model_pick(input logic [3:0] eff, input int ptr);
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = (ptr + i) % 4;
      if (eff[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      checks++;
      if (bus.oGrant !== e.grant) begin
        errors++;
        $display("FAIL sb_grant: got %b want %b at %0t", bus.oGrant, e.grant, $time);
      end
      checks++;
      if ({bus.oRed, bus.oGreen, bus.oBlue} !== e.rgb) begin
        errors++;
        $display("FAIL sb_colour: got %h want %h at %0t", {bus.oRed, bus.oGreen, bus.oBlue}, e.rgb, $time);
      end
      checks++;
      if (bus.oValid !== e.valid) begin
        errors++;
        $display("FAIL sb_valid: got %b want %b at %0t", bus.oValid, e.valid, $time);
      end
    end
  end

  task automatic drive_pixel(input logic v, input logic fs, input logic [3:0] req,
                             input logic we, input logic [3:0] mask);
    exp_t e;
    logic [3:0] eff;
    @(negedge clk);
    bus.iValid      = v;
    bus.iFrameStart = fs;
    bus.iReq        = req;
    bus.iRrEn       = rr_en;
    bus.iCfgWe      = we;
    bus.iCfgMask    = mask;
    eff = req & m_active;
    if (we) m_shadow = mask;
    if (fs) begin
      m_active = we ? mask : m_shadow;
      m_ptr    = rr_en ? ((m_ptr == 3) ? 0 : m_ptr + 1) : 0;
    end
    e.valid = v;
    e.grant = v ? model_pick(eff, m_ptr) : 4'b0000;
    e.rgb   = 30'h0;
    for (int k = 0; k < 4; k++) if (e.grant[k]) e.rgb = rgb_tab[k];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.iValid      = 1'b0;
    bus.iFrameStart = 1'b0;
    bus.iReq        = 4'b0000;
    bus.iCfgWe      = 1'b0;
    bus.iCfgMask    = 4'b0000;
    sb.delete();
    m_ptr    = 0;
    m_active = 4'hF;
    m_shadow = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.oRed, bus.oGreen, bus.oBlue} !== 30'h0) begin
      errors++; $display("FAIL rst_colour: got %h want 0", {bus.oRed, bus.oGreen, bus.oBlue});
    end
    checks++;
    if (bus.oValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.oValid); end
    checks++;
    if (bus.oGrant !== 4'b0) begin errors++; $display("FAIL rst_grant: got %b want 0", bus.oGrant); end
    checks++;
    if (bus.oCollision !== 4'b0) begin errors++; $display("FAIL rst_coll: got %b want 0", bus.oCollision); end
    checks++;
    if (bus.oCfgPending !== 1'b0) begin errors++; $display("FAIL rst_pend: got %b want 0", bus.oCfgPending); end
    for (int i = 0; i < 3; i++) drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oValid !== 1'b1 || bus.oGrant !== 4'b0) begin
      errors++; $display("FAIL idle_bg: got valid=%b grant=%b want valid=1 grant=0000", bus.oValid, bus.oGrant);
    end
  endtask

  task automatic test_fixed_priority();
    rr_en = 1'b0;
    rgb_tab[1] = {10'h3FF, 10'h000, 10'h000};
    rgb_tab[2] = {10'h000, 10'h3FF, 10'h000};
    drive_pixel(1'b1, 1'b0, 4'b0110, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0000) begin errors++; $display("FAIL fixed_early: got %b want 0000", bus.oGrant); end
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0010) begin errors++; $display("FAIL fixed_grant: got %b want 0010", bus.oGrant); end
    checks++;
    if (bus.oRed !== 10'h3FF || bus.oGreen !== 10'h000) begin
      errors++; $display("FAIL fixed_rgb: got r=%h g=%h want r=3ff g=000", bus.oRed, bus.oGreen);
    end
    drive_pixel(1'b0, 1'b0, 4'b0110, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1100, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
  endtask

  task automatic test_round_robin();
    logic [3:0] want [5];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
    rr_en = 1'b1;
    for (int i = 0; i < 3; i++) drive_pixel(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0);
    for (int f = 0; f < 5; f++) begin
      drive_pixel(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0);
      drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
      checks++;
      if (bus.oGrant !== want[f]) begin
        errors++; $display("FAIL rr_frame%0d: got %b want %b", f, bus.oGrant, want[f]);
      end
      drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    end
    rr_en = 1'b0;
    drive_pixel(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0001) begin errors++; $display("FAIL rr_off: got %b want 0001", bus.oGrant); end
  endtask

  task automatic test_collision();
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oCollision !== 4'b1111) begin errors++; $display("FAIL coll_boundary: got %b want 1111", bus.oCollision); end
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1001, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.oCollision !== 4'b1001) begin errors++; $display("FAIL coll_hold%0d: got %b want 1001", i, bus.oCollision); end
      drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    end
    drive_pixel(1'b1, 1'b1, 4'b0110, 1'b0, 4'b0);
    checks++;
    if (bus.oCollision !== 4'b0000) begin errors++; $display("FAIL coll_clear: got %b want 0000", bus.oCollision); end
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oCollision !== 4'b0110) begin errors++; $display("FAIL coll_fs_pixel: got %b want 0110", bus.oCollision); end
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1100, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oCollision !== 4'b0000) begin errors++; $display("FAIL coll_last_early: got %b want 0000", bus.oCollision); end
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oCollision !== 4'b1100) begin errors++; $display("FAIL coll_last_px: got %b want 1100", bus.oCollision); end
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0);
    checks++;
    if (bus.oCollision !== 4'b0000) begin errors++; $display("FAIL coll_final: got %b want 0000", bus.oCollision); end
  endtask

  task automatic test_config();
    drive_pixel(1'b1, 1'b1, 4'b0011, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oCfgPending !== 1'b0) begin errors++; $display("FAIL cfg_idle: got %b want 0", bus.oCfgPending); end
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b1, 4'b0100);
    checks++;
    if (bus.oCfgPending !== 1'b1) begin errors++; $display("FAIL cfg_pend: got %b want 1", bus.oCfgPending); end
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b1, 4'b1110);
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0001) begin errors++; $display("FAIL cfg_not_yet: got %b want 0001", bus.oGrant); end
    checks++;
    if (bus.oCfgPending !== 1'b1) begin errors++; $display("FAIL cfg_pend_hold: got %b want 1", bus.oCfgPending); end
    drive_pixel(1'b1, 1'b1, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oCfgPending !== 1'b0) begin errors++; $display("FAIL cfg_pend_clr: got %b want 0", bus.oCfgPending); end
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0001) begin errors++; $display("FAIL cfg_fs_px: got %b want 0001", bus.oGrant); end
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0010) begin errors++; $display("FAIL cfg_applied: got %b want 0010", bus.oGrant); end
    drive_pixel(1'b1, 1'b1, 4'b0011, 1'b1, 4'b1101);
    checks++;
    if (bus.oCfgPending !== 1'b0) begin errors++; $display("FAIL cfg_coinc_pend: got %b want 0", bus.oCfgPending); end
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0010) begin errors++; $display("FAIL cfg_coinc_old: got %b want 0010", bus.oGrant); end
    drive_pixel(1'b1, 1'b0, 4'b0011, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0001) begin errors++; $display("FAIL cfg_coinc_new: got %b want 0001", bus.oGrant); end
  endtask

  task automatic test_reset_midframe();
    rr_en = 1'b1;
    drive_pixel(1'b1, 1'b1, 4'b0000, 1'b1, 4'b1111);
    drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b1, 4'b1010, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1010, 1'b1, 4'b0001);
    checks++;
    if (bus.oCollision !== 4'b1111 || bus.oCfgPending !== 1'b1) begin
      errors++; $display("FAIL pre_rst: got coll=%b pend=%b want coll=1111 pend=1", bus.oCollision, bus.oCfgPending);
    end
    apply_reset();
    checks++;
    if ({bus.oRed, bus.oGreen, bus.oBlue, bus.oValid, bus.oGrant, bus.oCollision, bus.oCfgPending} !== 40'h0) begin
      errors++; $display("FAIL mid_rst_outs: got grant=%b coll=%b pend=%b valid=%b want all 0",
                         bus.oGrant, bus.oCollision, bus.oCfgPending, bus.oValid);
    end
    rr_en = 1'b0;
    drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0001) begin errors++; $display("FAIL mid_rst_ptr: got %b want 0001", bus.oGrant); end
    drive_pixel(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    drive_pixel(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0);
    checks++;
    if (bus.oGrant !== 4'b0001) begin errors++; $display("FAIL mid_rst_mask: got %b want 0001", bus.oGrant); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) rgb_tab[k] = 30'($urandom);
    for (int i = 0; i < 300; i++) begin
      if (i % 100 == 0) rr_en = ~rr_en;
      drive_pixel($urandom_range(0, 7) != 0, (i % 23) == 0, 4'($urandom),
                  $urandom_range(0, 15) == 0, 4'($urandom));
    end
    drive_pixel(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0);
    drive_pixel(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) rgb_tab[k] = {10'(k * 100 + 1), 10'(10'h3FF - k), 10'(k + 5)};
    bus.iValid      = 1'b0;
    bus.iFrameStart = 1'b0;
    bus.iReq        = 4'b0000;
    bus.iRrEn       = 1'b0;
    bus.iCfgWe      = 1'b0;
    bus.iCfgMask    = 4'b0000;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_collision();
    test_config();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
